// File: rtl/scaled_sum_accum_if.sv
// Stream interface for scaled_sum_accum: sample input handshake, flush,
// and the registered frame-result handshake.
interface scaled_sum_accum_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 3,
  parameter int SUM_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [SUM_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH:0]    out_count;
  logic                  out_ovf;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_sum, out_count, out_ovf, out_valid
  );

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_sum, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/scaled_sum_accum.sv
// Accumulates SAMPLES scaled samples (or fewer, on flush) into one frame sum.
// Define SCALED_SUM_ACCUM_SATURATE_EN to clamp the sum at all-ones on overflow.
module scaled_sum_accum #(
  parameter int DATA_WIDTH = 6,
  parameter int SAMPLES    = 4,
  parameter int CNT_WIDTH  = 3,
  parameter int SUM_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  scaled_sum_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  // The count is one bit wider than CNT_WIDTH so SAMPLES == 2**CNT_WIDTH fits.
  localparam logic [CNT_WIDTH:0] SAMPLES_C = (CNT_WIDTH+1)'(SAMPLES);
  localparam logic [CNT_WIDTH:0] ONE_C     = (CNT_WIDTH+1)'(1);

  state_e                 state_q, state_d;
  logic [SUM_WIDTH-1:0]   acc_q, acc_d, acc_next;
  logic [CNT_WIDTH:0]     cnt_q, cnt_d, cnt_next;
  logic                   ovf_q, ovf_d, ovf_next;
  logic [SUM_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [CNT_WIDTH:0]     out_count_q, out_count_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [SUM_WIDTH:0]     sum_ext;
  logic                   accept;
  logic                   close;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    close       = 1'b0;

    // The extra top bit catches the carry that marks the frame as overflowed.
    sum_ext  = {1'b0, acc_q} + (SUM_WIDTH+1)'(bus.in_data);
    ovf_next = ovf_q | sum_ext[SUM_WIDTH];
`ifdef SCALED_SUM_ACCUM_SATURATE_EN
    acc_next = ovf_next ? '1 : sum_ext[SUM_WIDTH-1:0];
`else
    acc_next = sum_ext[SUM_WIDTH-1:0];
`endif
    cnt_next = cnt_q + ONE_C;
    accept   = bus.in_valid && (state_q != HOLD);

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          ovf_d = ovf_next;
        end
        // A flush only closes a frame that already holds at least one sample.
        close = (accept && (cnt_next == SAMPLES_C)) || ((state_q == ACCUM) && bus.flush);
        if (close) begin
          state_d     = HOLD;
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
          out_ovf_d   = ovf_d;
          out_valid_d = 1'b1;
        end else if (accept) begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule
